// File: rtl/tdm_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_if
// Brief    : Bundle of serial-link inputs and per-channel outputs for the
//            TDM demultiplexer. The master side drives the link; the slave
//            side is the demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface tdm_demux_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 8
);
  localparam int SLOT_W = $clog2(NCH);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sof;
  logic [NCH*DATA_W-1:0] out_data;
  logic [NCH-1:0]        out_valid;
  logic                  frame_done;
  logic                  locked;
  logic                  sync_err;
  logic [SLOT_W-1:0]     slot;

  modport master (
    output in_valid, in_data, in_sof,
    input  out_data, out_valid, frame_done, locked, sync_err, slot
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output out_data, out_valid, frame_done, locked, sync_err, slot
  );
endinterface
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Brief    : Registered 1-to-NCH time-division demultiplexer. Recovers the
//            slot position from the start-of-frame flag, routes each sample
//            to its channel holding register, strobes per-channel valid and
//            flags framing errors (early or missing SOF).
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
  parameter int NCH    = 4,
  parameter int DATA_W = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  tdm_demux_if.slave      bus
);
  localparam int SLOT_W = $clog2(NCH);

  localparam logic [SLOT_W-1:0] c_SLOT_ZERO = '0;
  localparam logic [SLOT_W-1:0] c_SLOT_ONE  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(NCH - 1);
  localparam logic [NCH-1:0]    c_CH0_MASK  = NCH'(1);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [SLOT_W-1:0]     r_slot;
  logic [NCH*DATA_W-1:0] r_out_data;
  logic [NCH-1:0]        r_out_valid;
  logic                  r_frame_done;
  logic                  r_sync_err;
  logic                  r_locked;

  logic [NCH-1:0]        w_slot_mask;
  logic [SLOT_W-1:0]     w_slot_next;
  logic                  w_slot_last;

  // One-hot strobe for the current slot and the wrapped successor slot
  // (wrap at NCH-1 keeps non-power-of-two NCH inside the legal range).
  assign w_slot_mask = c_CH0_MASK << r_slot;
  assign w_slot_last = (r_slot == c_SLOT_LAST);
  assign w_slot_next = w_slot_last ? c_SLOT_ZERO : r_slot + c_SLOT_ONE;

  // Framing FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_slot       <= c_SLOT_ZERO;
      r_out_data   <= '0;
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      // Strobes default low; only a triggering event raises them.
      r_out_valid  <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (bus.in_valid) begin
        case (r_state)
          ST_HUNT: begin
            // Samples without SOF are dropped silently while hunting.
            if (bus.in_sof) begin
              r_out_data[DATA_W-1:0] <= bus.in_data;
              r_out_valid            <= c_CH0_MASK;
              r_slot                 <= c_SLOT_ONE;
              r_state                <= ST_LOCKED;
              r_locked               <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (bus.in_sof && (r_slot != c_SLOT_ZERO)) begin
              // Early SOF: realign on this sample, leave later channels alone.
              r_sync_err             <= 1'b1;
              r_out_data[DATA_W-1:0] <= bus.in_data;
              r_out_valid            <= c_CH0_MASK;
              r_slot                 <= c_SLOT_ONE;
            end else if (!bus.in_sof && (r_slot == c_SLOT_ZERO)) begin
              // Missing SOF: drop the sample and fall back to hunting.
              r_sync_err <= 1'b1;
              r_state    <= ST_HUNT;
              r_locked   <= 1'b0;
            end else begin
              r_out_data[r_slot*DATA_W +: DATA_W] <= bus.in_data;
              r_out_valid                         <= w_slot_mask;
              r_frame_done                        <= w_slot_last;
              r_slot                              <= w_slot_next;
            end
          end
          default: begin
            r_state  <= ST_HUNT;
            r_slot   <= c_SLOT_ZERO;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
  assign bus.locked     = r_locked;
  assign bus.slot       = r_slot;

endmodule
`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Registered 1-to-NCH time-division demultiplexer; the receive end of a select-driven mux link.
- An upstream mux serialises NCH channels onto one data line, one sample per slot, and marks slot 0 with a start-of-frame flag.
- This block recovers the slot position, routes each sample to its channel holding register, strobes per-channel valid and flags framing errors.

Parameters:
- NCH, 4, number of channels/slots per frame; legal range 2..16.
- DATA_W, 8, width of one sample in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data carries a sample this cycle.
- in_data  input  DATA_W  serial-link sample.
- in_sof  input  1  start of frame; marks the current sample as slot 0; meaningful only when in_valid=1.
- out_data  output  NCH*DATA_W  channel k holding register at bits [k*DATA_W +: DATA_W].
- out_valid  output  NCH  bit k is a one-cycle strobe: channel k updated this cycle.
- frame_done  output  1  one-cycle pulse: slot NCH-1 captured.
- locked  output  1  1 while in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing error.
- slot  output  clog2(NCH)  slot index expected for the next sample (debug).

Behaviour:
- Reset, asynchronous on rst_n=0:
  - out_data=0, out_valid=0, frame_done=0, sync_err=0, locked=0, slot=0.
  - State returns to HUNT, including mid-frame.
  - Release is synchronous: first capture can occur on the first rising edge with rst_n=1.
- All outputs are registered. A sample accepted at edge N appears on out_data/out_valid after edge N, i.e. one-cycle latency.
- Idle cycles: in_valid=0 cycles are allowed anywhere and do not advance slot. out_valid, frame_done and sync_err are 0 in any cycle without a triggering event.
- HUNT state:
  - in_valid=1, in_sof=0: sample dropped, no output change, no sync_err.
  - in_valid=1, in_sof=1: sample written to channel 0, out_valid[0]=1, slot<=1, go LOCKED.
- LOCKED state, in_valid=1:
  - in_sof=0, slot!=0: sample written to channel slot, out_valid[slot]=1. slot increments and wraps from NCH-1 to 0. Writing slot NCH-1 also pulses frame_done.
  - in_sof=1, slot==0: normal frame start, same as the row above for channel 0.
  - in_sof=1, slot!=0 (early SOF): sync_err=1, realign. Sample written to channel 0, out_valid[0]=1, slot<=1, stay LOCKED. No frame_done. Channels beyond the truncated frame keep their old values.
  - in_sof=0, slot==0 (missing SOF): sync_err=1, sample dropped, go HUNT, slot stays 0.
- Holding registers: hold their value until rewritten. Exactly one out_valid bit may be high per cycle.
- NCH=2 edge case: slot is 1 bit and the wrap is 1->0.
- Non-power-of-two NCH: slot never exceeds NCH-1.
- No backpressure: every in_valid sample is consumed or dropped in its own cycle.

Test Plan:
- Reset/defaults: hold rst_n=0 for 3 cycles with random inputs -> all outputs 0, locked=0. Assert rst_n=0 mid-frame after slot 2 -> outputs clear immediately without waiting for a clock edge, locked=0.
- Lock-up and a clean frame, NCH=4, DATA_W=8:
  - Drive 0x11 and 0x22 without SOF -> dropped, locked stays 0.
  - Then drive 0xA0 with SOF, followed by 0xA1, 0xA2, 0xA3 -> out_valid sequence 0001, 0010, 0100, 1000, each one cycle after its sample.
  - After the frame: out_data=0xA3A2A1A0, frame_done pulses together with out_valid[3], locked=1.
- Gapped input: same frame with in_valid=0 for 2 cycles between every sample -> identical final out_data. slot does not advance during gaps, out_valid is 0 in gap cycles.
- Early SOF: after 0xB0(SOF) and 0xB1, drive 0xC0 with SOF -> sync_err pulse, channel 0=0xC0, slot=1, locked=1, channel 2/3 unchanged, no frame_done.
- Missing SOF: after a complete frame, drive 0xD0 without SOF -> sync_err pulse, locked=0, out_data unchanged. A following 0xE0 with SOF relocks with channel 0=0xE0.
- Back-to-back frames: 8 consecutive valid samples 0x00..0x07, SOF on 0x00 and 0x04 -> frame_done on 0x03 and 0x07, final out_data=0x07060504, sync_err never asserted.
